// File: rtl/pipe_stall_ctrl_pkg.sv
// Shared definitions for the pipeline stall controller: stall codes,
// structural-hazard FSM states, Stop/NoStop and bus-owner encodings.
package pipe_stall_ctrl_pkg;

   localparam int STALL_W = 6;
   typedef logic [STALL_W-1:0] stall_t;

   // One bit per pipeline register: [0]=PC [1]=IF/ID [2]=ID/EX [3]=EX/MEM [4]=MEM/WB [5]=WB.
   // Each code freezes every stage upstream of the requesting one.
   localparam stall_t STALL_NONE = 6'b000000;
   localparam stall_t STALL_IF   = 6'b000011;  // refetch: PC held, IF/ID bubble
   localparam stall_t STALL_ID   = 6'b000111;
   localparam stall_t STALL_EX   = 6'b001111;
   localparam stall_t STALL_MEM  = 6'b011111;

   localparam logic STOP    = 1'b1;
   localparam logic NO_STOP = 1'b0;

   localparam logic BUS_IF  = 1'b0;
   localparam logic BUS_MEM = 1'b1;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      MEM_BUSY = 2'd1,
      REFETCH  = 2'd2
   } fsm_state_t;

   // Bits needed to hold values 0..max_val (at least one bit).
   function automatic int cnt_width(input int unsigned max_val);
      return (max_val > 1) ? $clog2(max_val + 1) : 1;
   endfunction

endpackage

// File: rtl/pipe_stall_ctrl_watchdog.sv
// Stall statistics: saturating count of stalled cycles plus a watchdog that
// raises a sticky flag after WDOG_LIMIT consecutive stalled cycles.
module stall_watchdog
   import pipe_stall_ctrl_pkg::*;
#(
   parameter int unsigned WDOG_LIMIT = 1024,
   parameter int unsigned CNT_W      = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stalled,
   input  logic             clr_stats,
   output logic [CNT_W-1:0] stall_cycles,
   output logic             stall_timeout
);

   localparam int              RUN_W   = cnt_width(WDOG_LIMIT - 1);
   localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(WDOG_LIMIT - 1);

   logic [RUN_W-1:0] run_cnt;

   // Count stalled cycles, track the current stall run and latch the timeout.
   // NOTE: every state register here is written with <= so all of them see
   // the pre-edge values of each other; a blocking = would create ordering bugs.
   always_ff @(posedge clk) begin
      if (rst || clr_stats) begin
         // Clear wins over a same-cycle increment or timeout set.
         stall_cycles  <= '0;
         stall_timeout <= 1'b0;
         run_cnt       <= '0;
      end else if (stalled) begin
         if (!(&stall_cycles)) begin
            stall_cycles <= stall_cycles + CNT_W'(1);
         end
         if (run_cnt == RUN_MAX) begin
            stall_timeout <= 1'b1;
         end else begin
            run_cnt <= run_cnt + RUN_W'(1);
         end
      end else begin
         run_cnt <= '0;
      end
   end

endmodule

// File: rtl/pipe_stall_ctrl.sv
// Central pipeline stall controller: shared base-SRAM structural-hazard FSM,
// fixed-priority stall encoder and stall statistics/watchdog.
module pipe_stall_ctrl
   import pipe_stall_ctrl_pkg::*;
#(
   parameter int unsigned MEM_WAIT   = 2,
   parameter int unsigned WDOG_LIMIT = 1024,
   parameter int unsigned CNT_W      = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stallreq_id,
   input  logic             stallreq_ex,
   input  logic             mem_bus_req,
   input  logic             clr_stats,
   output logic [5:0]       stall,
   output logic             bus_owner,
   output logic [CNT_W-1:0] stall_cycles,
   output logic             stall_timeout
);

   localparam int               WAIT_W      = cnt_width(MEM_WAIT);
   localparam logic [WAIT_W-1:0] WAIT_LOAD   = (MEM_WAIT > 0) ? WAIT_W'(MEM_WAIT - 1) : '0;
   // With no wait cycles the access goes straight to the refetch cycle.
   localparam fsm_state_t       ENTRY_STATE = (MEM_WAIT > 0) ? MEM_BUSY : REFETCH;

   fsm_state_t        state;
   logic [WAIT_W-1:0] wait_cnt;
   stall_t            stall_code;

   // Shared-SRAM hazard FSM; bus_owner is registered alongside the state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         wait_cnt  <= '0;
         bus_owner <= BUS_IF;
      end else begin
         case (state)
            IDLE: begin
               // The request is only sampled here, so a request still held
               // through REFETCH cannot retrigger a second access.
               if (mem_bus_req) begin
                  state     <= ENTRY_STATE;
                  wait_cnt  <= WAIT_LOAD;
                  bus_owner <= BUS_MEM;
               end
            end
            MEM_BUSY: begin
               if (wait_cnt == '0) begin
                  state <= REFETCH;
               end else begin
                  wait_cnt <= wait_cnt - WAIT_W'(1);
               end
            end
            REFETCH: begin
               state     <= IDLE;
               bus_owner <= BUS_IF;
            end
            default: begin
               state     <= IDLE;
               bus_owner <= BUS_IF;
            end
         endcase
      end
   end

   // Fixed-priority stall encoder: the most downstream requester wins.
   // NOTE: stall_code gets a default before the if-chain so every path
   // assigns it and no latch is inferred.
   always_comb begin
      stall_code = STALL_NONE;
      if (state == MEM_BUSY) begin
         stall_code = STALL_MEM;
      end else if (stallreq_ex) begin
         stall_code = STALL_EX;
      end else if (stallreq_id) begin
         stall_code = STALL_ID;
      end else if (state == REFETCH) begin
         stall_code = STALL_IF;
      end
   end

   // No code sets bit 5, so the WB stage is never frozen.
   assign stall = stall_code;

   stall_watchdog #(
      .WDOG_LIMIT (WDOG_LIMIT),
      .CNT_W      (CNT_W)
   ) u_watchdog (
      .clk           (clk),
      .rst           (rst),
      .stalled       (stall_code != STALL_NONE),
      .clr_stats     (clr_stats),
      .stall_cycles  (stall_cycles),
      .stall_timeout (stall_timeout)
   );

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Self-checking bench for pipe_stall_ctrl: a MEM_WAIT=2/WDOG_LIMIT=8 instance
// driven from a vector table through a scoreboard, and a MEM_WAIT=0,
// WDOG_LIMIT=1, CNT_W=4 instance for the zero-wait and saturation corners.
module tb_pipe_stall_ctrl;
   import pipe_stall_ctrl_pkg::*;

   localparam int unsigned CNT_W = 32;

   logic             clk = 1'b0;
   logic             rst;
   logic             stallreq_id, stallreq_ex, mem_bus_req, clr_stats;
   logic [5:0]       stall;
   logic             bus_owner;
   logic [CNT_W-1:0] stall_cycles;
   logic             stall_timeout;

   logic             id0, ex0, mem0, clr0;
   logic [5:0]       stall0;
   logic             owner0;
   logic [3:0]       cycles0;
   logic             timeout0;

   always #5 clk = ~clk;

   pipe_stall_ctrl #(.MEM_WAIT(2), .WDOG_LIMIT(8), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .stallreq_id(stallreq_id), .stallreq_ex(stallreq_ex),
      .mem_bus_req(mem_bus_req), .clr_stats(clr_stats), .stall(stall),
      .bus_owner(bus_owner), .stall_cycles(stall_cycles), .stall_timeout(stall_timeout)
   );

   pipe_stall_ctrl #(.MEM_WAIT(0), .WDOG_LIMIT(1), .CNT_W(4)) dut0 (
      .clk(clk), .rst(rst), .stallreq_id(id0), .stallreq_ex(ex0),
      .mem_bus_req(mem0), .clr_stats(clr0), .stall(stall0),
      .bus_owner(owner0), .stall_cycles(cycles0), .stall_timeout(timeout0)
   );

   typedef struct {
      logic       id, ex, mem, clr;
      logic [5:0] exp_stall;
      logic       exp_owner;
   } vec_t;

   typedef struct {
      logic [5:0] stall;
      logic       owner;
      string      tag;
   } sb_t;

   sb_t              sb[$];
   vec_t             tbl[23];
   int               n_checks = 0;
   int               n_fail   = 0;
   logic [CNT_W-1:0] exp_cycles;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic id, input logic ex, input logic mem,
                               input logic clr, input logic [5:0] st, input logic own);
      vec_t v;
      v.id = id; v.ex = ex; v.mem = mem; v.clr = clr;
      v.exp_stall = st; v.exp_owner = own;
      return v;
   endfunction

   // Scoreboard monitor: compare mid-cycle against the oldest expectation.
   always @(negedge clk) begin : monitor
      sb_t e;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         check({e.tag, " stall"}, 64'(stall), 64'(e.stall));
         check({e.tag, " bus_owner"}, 64'(bus_owner), 64'(e.owner));
      end
   end

   // Drive one cycle on the main instance (called just after a rising edge).
   task automatic cyc(input vec_t v, input string tag);
      stallreq_id = v.id;
      stallreq_ex = v.ex;
      mem_bus_req = v.mem;
      clr_stats   = v.clr;
      sb.push_back('{stall: v.exp_stall, owner: v.exp_owner, tag: tag});
      @(posedge clk);
      #1;
      if (rst || v.clr) exp_cycles = '0;
      else if (v.exp_stall != STALL_NONE) exp_cycles = exp_cycles + 1'b1;
   endtask

   // Drive one cycle on the zero-wait instance and check it mid-cycle.
   task automatic cyc0(input logic id, input logic ex, input logic mem, input logic clr,
                       input logic [5:0] st, input logic own, input string tag);
      id0 = id; ex0 = ex; mem0 = mem; clr0 = clr;
      @(negedge clk);
      check({tag, " stall"}, 64'(stall0), 64'(st));
      check({tag, " bus_owner"}, 64'(owner0), 64'(own));
      @(posedge clk);
      #1;
   endtask

   initial begin : watchdog_timer
      #50000;
      $display("FAIL global_timeout: simulation did not finish in time");
      $fatal(1, "bench timeout");
   end

   initial begin
      // Single access, held request, priority, EX during MEM_BUSY, back-to-back.
      tbl[0]  = mk(0, 0, 1, 0, STALL_NONE, 0);
      tbl[1]  = mk(0, 0, 1, 0, STALL_MEM,  1);
      tbl[2]  = mk(0, 0, 1, 0, STALL_MEM,  1);
      tbl[3]  = mk(0, 0, 1, 0, STALL_IF,   1);
      tbl[4]  = mk(0, 0, 0, 0, STALL_NONE, 0);
      tbl[5]  = mk(0, 0, 0, 0, STALL_NONE, 0);
      tbl[6]  = mk(1, 1, 0, 0, STALL_EX,   0);
      tbl[7]  = mk(1, 0, 0, 0, STALL_ID,   0);
      tbl[8]  = mk(0, 1, 0, 0, STALL_EX,   0);
      tbl[9]  = mk(0, 0, 1, 0, STALL_NONE, 0);
      tbl[10] = mk(0, 1, 1, 0, STALL_MEM,  1);
      tbl[11] = mk(0, 1, 1, 0, STALL_MEM,  1);
      tbl[12] = mk(0, 1, 0, 0, STALL_EX,   1);
      tbl[13] = mk(1, 0, 0, 0, STALL_ID,   0);
      tbl[14] = mk(0, 0, 1, 0, STALL_NONE, 0);
      tbl[15] = mk(0, 0, 1, 0, STALL_MEM,  1);
      tbl[16] = mk(0, 0, 1, 0, STALL_MEM,  1);
      tbl[17] = mk(1, 0, 1, 0, STALL_ID,   1);
      tbl[18] = mk(0, 0, 1, 0, STALL_NONE, 0);
      tbl[19] = mk(0, 0, 0, 0, STALL_MEM,  1);
      tbl[20] = mk(0, 0, 0, 0, STALL_MEM,  1);
      tbl[21] = mk(0, 0, 0, 0, STALL_IF,   1);
      tbl[22] = mk(0, 0, 0, 0, STALL_NONE, 0);

      // Reset with every request high on the main instance.
      rst = 1'b1;
      stallreq_id = 1'b1; stallreq_ex = 1'b1; mem_bus_req = 1'b1; clr_stats = 1'b1;
      id0 = 1'b0; ex0 = 1'b0; mem0 = 1'b0; clr0 = 1'b0;
      exp_cycles = '0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      stallreq_id = 1'b0; stallreq_ex = 1'b0; mem_bus_req = 1'b0; clr_stats = 1'b0;
      @(negedge clk);
      check("reset stall", 64'(stall), 64'(STALL_NONE));
      check("reset bus_owner", 64'(bus_owner), 64'(BUS_IF));
      check("reset stall_cycles", 64'(stall_cycles), 64'd0);
      check("reset stall_timeout", 64'(stall_timeout), 64'd0);
      @(posedge clk);
      #1;

      for (int i = 0; i < 23; i++) begin
         cyc(tbl[i], $sformatf("vec%0d", i));
         if (i == 4) check("single_access stall_cycles", 64'(stall_cycles), 64'd3);
      end
      check("table stall_cycles", 64'(stall_cycles), 64'(exp_cycles));
      check("table stall_timeout", 64'(stall_timeout), 64'd0);

      // Watchdog: clear wins over a stalled-cycle increment, then 8 stalled cycles.
      cyc(mk(1, 0, 0, 1, STALL_ID, 0), "wd_clr_inc");
      check("clr_wins_inc stall_cycles", 64'(stall_cycles), 64'd0);
      repeat (7) cyc(mk(1, 0, 0, 0, STALL_ID, 0), "wd_run");
      check("wd_before_limit timeout", 64'(stall_timeout), 64'd0);
      check("wd_before_limit stall_cycles", 64'(stall_cycles), 64'd7);
      cyc(mk(1, 0, 0, 0, STALL_ID, 0), "wd_run8");
      check("wd_at_limit timeout", 64'(stall_timeout), 64'd1);
      check("wd_at_limit stall_cycles", 64'(stall_cycles), 64'd8);
      repeat (2) cyc(mk(0, 0, 0, 0, STALL_NONE, 0), "wd_release");
      check("wd_sticky timeout", 64'(stall_timeout), 64'd1);
      cyc(mk(0, 0, 0, 1, STALL_NONE, 0), "wd_clr");
      check("wd_clr timeout", 64'(stall_timeout), 64'd0);
      check("wd_clr stall_cycles", 64'(stall_cycles), 64'd0);

      // An unstalled cycle restarts the run; then clear wins over the set.
      repeat (7) cyc(mk(1, 0, 0, 0, STALL_ID, 0), "wd_runa");
      cyc(mk(0, 0, 0, 0, STALL_NONE, 0), "wd_gap");
      repeat (7) cyc(mk(1, 0, 0, 0, STALL_ID, 0), "wd_runb");
      check("wd_run_clears timeout", 64'(stall_timeout), 64'd0);
      check("wd_run_clears stall_cycles", 64'(stall_cycles), 64'(exp_cycles));
      cyc(mk(1, 0, 0, 1, STALL_ID, 0), "wd_clr_set");
      check("clr_wins_set timeout", 64'(stall_timeout), 64'd0);
      check("clr_wins_set stall_cycles", 64'(stall_cycles), 64'd0);
      cyc(mk(0, 0, 0, 0, STALL_NONE, 0), "wd_idle");

      // Reset in the middle of MEM_BUSY.
      cyc(mk(0, 0, 1, 0, STALL_NONE, 0), "rb_req");
      cyc(mk(0, 0, 0, 0, STALL_MEM, 1), "rb_busy");
      rst = 1'b1;
      cyc(mk(0, 0, 0, 0, STALL_MEM, 1), "rb_rst");
      rst = 1'b0;
      cyc(mk(0, 0, 0, 0, STALL_NONE, 0), "rb_after");
      cyc(mk(0, 0, 0, 0, STALL_NONE, 0), "rb_after2");
      check("rb stall_cycles", 64'(stall_cycles), 64'(exp_cycles));
      check("rb stall_timeout", 64'(stall_timeout), 64'd0);

      // MEM_WAIT=0 instance: one refetch cycle per access, held req ignored.
      cyc0(0, 0, 1, 0, STALL_NONE, 0, "z_req");
      cyc0(0, 0, 1, 0, STALL_IF,   1, "z_refetch");
      cyc0(0, 0, 0, 0, STALL_NONE, 0, "z_idle");
      check("z stall_cycles", 64'(cycles0), 64'd1);
      check("z limit1 timeout", 64'(timeout0), 64'd1);
      cyc0(0, 0, 0, 1, STALL_NONE, 0, "z_clr");
      check("z_clr timeout", 64'(timeout0), 64'd0);
      check("z_clr stall_cycles", 64'(cycles0), 64'd0);
      for (int i = 0; i < 20; i++) cyc0(0, 1, 0, 0, STALL_EX, 0, "z_sat");
      check("z saturate stall_cycles", 64'(cycles0), 64'd15);
      check("z saturate timeout", 64'(timeout0), 64'd1);
      cyc0(0, 0, 0, 0, STALL_NONE, 0, "z_end");

      check("scoreboard drained", 64'(sb.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
